bus_xfer_ctrl: RTL and testbench
================================

// Module: bus_xfer_ctrl
// PURPOSE
//  Sequences register-to-register moves over the shared tri-state data bus (pc/ac/ar-style registers with CS/OE/WE).
//  Arbitrates round-robin between NUM_REQ requesters; each request names a source and destination register.
//  Drives per-register CS/OE/WE so at most one OE is active per cycle, with a dead turnaround cycle after every move.
//  Sits between the control unit and the register file.
// PARAMETERS
//  NUM_REGS   4  registers on the bus (strobe vector width)
//  NUM_REQ    2  requesters
//  SEL_WIDTH  2  register-select width; must satisfy 2**SEL_WIDTH >= NUM_REGS
// PORTS
//  clk      in   1                  system clock, all state on posedge
//  reset    in   1                  asynchronous, active-low; clears all state
//  req      in   NUM_REQ            transfer request per requester, level
//  src_sel  in   NUM_REQ*SEL_WIDTH  source register index, requester i at [i*SEL_WIDTH +: SEL_WIDTH]
//  dst_sel  in   NUM_REQ*SEL_WIDTH  destination register index, same packing
//  gnt      out  NUM_REQ            one-hot, 1-cycle pulse: selects latched for requester i
//  done     out  NUM_REQ            one-hot, 1-cycle pulse: destination captures on this cycle's closing edge
//  err      out  1                  1-cycle pulse with done: request was illegal, no strobes driven
//  busy     out  1                  1 in every state except IDLE
//  CS       out  NUM_REGS           per-register chip select
//  OE       out  NUM_REGS           per-register bus-drive enable
//  WE       out  NUM_REGS           per-register write enable
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, rr_ptr=0, latched sel=0; all outputs 0 immediately, including mid-transfer.
//  FSM (Moore outputs, registered state): IDLE -> ARB -> DRIVE -> WRITE -> DONE -> IDLE.
//   IDLE : any req=1 at posedge -> ARB. Winner = first set req at or after rr_ptr, wrapping; src/dst latched on that edge.
//   ARB  : gnt[w]=1. Legal -> DRIVE. Illegal (src==dst, or either index >= NUM_REGS) -> WRITE, strobes stay off.
//   DRIVE: CS[src]=OE[src]=1; bus settles.
//   WRITE: CS[src]=OE[src]=1, CS[dst]=WE[dst]=1; done[w]=1 (err=1 if illegal). Dst loads on the closing edge.
//   DONE : all strobes 0 (turnaround). rr_ptr <= (w+1) mod NUM_REQ. -> IDLE.
//  Latency: req sampled at edge E0 -> gnt in E0..E1, done in E2..E3, bus free (IDLE) after E4. One move per 5 cycles.
//  Requester holds req/src_sel/dst_sel stable until gnt, and drops req no later than the edge ending done.
//  A req still high in DONE/IDLE is a new request.
//  req falling after gnt: ignored, move completes. Selects changing after gnt: ignored (latched copy used).
//  Simultaneous reqs: round-robin only; the winner always gets priority below every other requester next time.
//  Invariant: popcount(OE) <= 1 every cycle; OE[k] implies CS[k]; WE[k] implies CS[k]; WE[k] & OE[k] never both 1.
// CONFIGURATION
//  BUS_XFER_B2B_EN defined:
//   DONE -> ARB directly when any req=1 at the DONE posedge; winner and rr_ptr update on the same edge.
//   Back-to-back moves every 4 cycles; turnaround cycle is retained.
//  BUS_XFER_B2B_EN undefined: DONE always -> IDLE; 5 cycles per move as above.
// TESTING
//  Single move:
//   req=01, src0=0, dst0=2, reset released -> gnt=01 at cycle 1, OE[0] cycles 2-3, WE[2] cycle 3 only, done=01 cycle 3.
//   Bus value 'hBF lands in reg2.
//  Contention:
//   req=11 held, rr_ptr=0 -> grant order 0,1,0,1; gnt never 11; no cycle with two OE bits set.
//  Illegal request:
//   src=dst=1 -> gnt, then done+err one cycle later; CS/OE/WE all 0 throughout. Same for dst=3 with NUM_REGS=3.
//  Reset mid-move:
//   reset=0 during WRITE -> CS/OE/WE/gnt/done=0 that cycle, busy=0; after release, rr_ptr=0 and a fresh req is served normally.
//  Back-to-back:
//   req=11 held, BUS_XFER_B2B_EN defined -> done pulses 4 cycles apart; undefined -> 5 cycles apart. OE low in every DONE cycle.
//  Late req drop:
//   req deasserted the cycle after gnt -> move still completes and done still pulses.

Source files
------------

// File: rtl/bus_xfer_if.sv
// Handshake and strobe bundle between the control unit, bus_xfer_ctrl and the register file.
// The master side is the requesting control unit; the slave side is bus_xfer_ctrl.
interface bus_xfer_if #(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned SEL_WIDTH = 2
) ();

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*SEL_WIDTH-1:0] src_sel;
  logic [NUM_REQ*SEL_WIDTH-1:0] dst_sel;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic                         err;
  logic                         busy;
  logic [NUM_REGS-1:0]          CS;
  logic [NUM_REGS-1:0]          OE;
  logic [NUM_REGS-1:0]          WE;

  modport master (
    output req, src_sel, dst_sel,
    input  gnt, done, err, busy, CS, OE, WE
  );

  modport slave (
    input  req, src_sel, dst_sel,
    output gnt, done, err, busy, CS, OE, WE
  );

endinterface

// File: rtl/bus_xfer_ctrl.sv
// Round-robin register-to-register move sequencer for a shared tri-state data bus.
// Define BUS_XFER_B2B_EN to let a pending request start straight from the turnaround cycle.
module bus_xfer_ctrl #(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  bus_xfer_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [SEL_WIDTH-1:0] sel_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_DRIVE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // A move is legal only between two distinct, existing registers.
  function automatic logic sel_legal(input sel_t s, input sel_t d);
    return (s != d) && (32'(s) < NUM_REGS) && (32'(d) < NUM_REGS);
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return ((32'(p) + 32'd1) >= NUM_REQ) ? '0 : p + PTR_W'(1);
  endfunction

  state_t state_q, state_d;
  ptr_t   rr_ptr_q, rr_ptr_d;
  ptr_t   win_q, win_d;
  sel_t   src_q, src_d;
  sel_t   dst_q, dst_d;

  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [NUM_REGS-1:0] cs_q, cs_d;
  logic [NUM_REGS-1:0] oe_q, oe_d;
  logic [NUM_REGS-1:0] we_q, we_d;

  sel_t src_arr [NUM_REQ];
  sel_t dst_arr [NUM_REQ];
  ptr_t arb_base;
  ptr_t arb_idx;
  ptr_t arb_win;
  logic arb_hit;
  logic legal_d;
  logic src_hit;
  logic dst_hit;

  // Unpack the per-requester select fields.
  always_comb begin : sel_unpack
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src_arr[i] = bus.src_sel[i*SEL_WIDTH +: SEL_WIDTH];
      dst_arr[i] = bus.dst_sel[i*SEL_WIDTH +: SEL_WIDTH];
    end
  end

  // In DONE the pointer is about to advance past the current winner, so search from there.
  always_comb begin : rr_arbiter
    arb_base = (state_q == S_DONE) ? ptr_inc(win_q) : rr_ptr_q;
    arb_idx  = arb_base;
    arb_win  = arb_base;
    arb_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_idx = PTR_W'((32'(arb_base) + i) % NUM_REQ);
      if (!arb_hit && bus.req[arb_idx]) begin
        arb_hit = 1'b1;
        arb_win = arb_idx;
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    src_d    = src_q;
    dst_d    = dst_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d = S_ARB;
          win_d   = arb_win;
          src_d   = src_arr[arb_win];
          dst_d   = dst_arr[arb_win];
        end
      end
      S_ARB:   state_d = sel_legal(src_q, dst_q) ? S_DRIVE : S_WRITE;
      S_DRIVE: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        rr_ptr_d = ptr_inc(win_q);
        state_d  = S_IDLE;
`ifdef BUS_XFER_B2B_EN
        if (arb_hit) begin
          state_d = S_ARB;
          win_d   = arb_win;
          src_d   = src_arr[arb_win];
          dst_d   = dst_arr[arb_win];
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin : next_outputs
    legal_d = sel_legal(src_d, dst_d);
    gnt_d   = '0;
    done_d  = '0;
    err_d   = (state_d == S_WRITE) && !legal_d;
    busy_d  = (state_d != S_IDLE);
    cs_d    = '0;
    oe_d    = '0;
    we_d    = '0;
    src_hit = 1'b0;
    dst_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win_d) begin
        gnt_d[i]  = (state_d == S_ARB);
        done_d[i] = (state_d == S_WRITE);
      end
    end
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      src_hit = legal_d && (SEL_WIDTH'(k) == src_d) &&
                ((state_d == S_DRIVE) || (state_d == S_WRITE));
      dst_hit = legal_d && (SEL_WIDTH'(k) == dst_d) && (state_d == S_WRITE);
      cs_d[k] = src_hit || dst_hit;
      oe_d[k] = src_hit;
      we_d[k] = dst_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : output_reg
    if (!reset) begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      cs_q   <= '0;
      oe_q   <= '0;
      we_q   <= '0;
    end else begin
      gnt_q  <= gnt_d;
      done_q <= done_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      cs_q   <= cs_d;
      oe_q   <= oe_d;
      we_q   <= we_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.CS   = cs_q;
  assign bus.OE   = oe_q;
  assign bus.WE   = we_q;

  // Bus-safety invariants on the registered strobes.
  a_oe_single: assert property (@(posedge clk) disable iff (!reset) $onehot0(oe_q));
  a_oe_cs:     assert property (@(posedge clk) disable iff (!reset) (oe_q & ~cs_q) == '0);
  a_we_cs:     assert property (@(posedge clk) disable iff (!reset) (we_q & ~cs_q) == '0);
  a_we_oe:     assert property (@(posedge clk) disable iff (!reset) (we_q & oe_q) == '0);
  a_gnt_one:   assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_q));
  a_done_one:  assert property (@(posedge clk) disable iff (!reset) $onehot0(done_q));

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed scenarios plus randomized traffic against a
// move-timeline reference model and a small register file on the data bus.
module tb_bus_xfer_ctrl;

  localparam int unsigned NREGS = 4;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned SW    = 2;
  localparam int unsigned PW    = 1;
`ifdef BUS_XFER_B2B_EN
  localparam int MOVE_GAP = 4;
`else
  localparam int MOVE_GAP = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_xfer_if #(.NUM_REGS(NREGS), .NUM_REQ(NREQ), .SEL_WIDTH(SW)) bus  ();
  bus_xfer_if #(.NUM_REGS(3),     .NUM_REQ(NREQ), .SEL_WIDTH(SW)) bus3 ();

  bus_xfer_ctrl #(.NUM_REGS(NREGS), .NUM_REQ(NREQ), .SEL_WIDTH(SW)) u_dut (
    .clk(clk), .reset(rst_n), .bus(bus.slave));
  bus_xfer_ctrl #(.NUM_REGS(3), .NUM_REQ(NREQ), .SEL_WIDTH(SW)) u_dut3 (
    .clk(clk), .reset(rst_n), .bus(bus3.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  // Register file hanging off the shared data bus.
  logic [7:0] rf [NREGS] = '{8'hBF, 8'h11, 8'h22, 8'h33};
  logic [7:0] dbus;
  always @* begin
    dbus = 8'h00;
    for (int k = 0; k < NREGS; k++) if (bus.OE[k]) dbus = dbus | rf[k];
  end
  always @(posedge clk) begin
    for (int k = 0; k < NREGS; k++) if (bus.WE[k]) rf[k] <= dbus;
  end

  // Reference model: a move is a timeline of phases counted from its grant.
  // Legal: grant, drive, write(done), turnaround. Illegal: grant, done+err, turnaround.
  logic [PW-1:0] m_ptr, m_w, n_ptr, n_w, cand;
  logic [SW-1:0] m_s, m_d, n_s, n_d;
  logic          m_act, m_ill, n_act, n_ill, start, found;
  int            m_phase, n_phase;

  always @* begin
    n_ptr = m_ptr; n_w = m_w; n_s = m_s; n_d = m_d; n_ill = m_ill;
    n_act = m_act; n_phase = m_phase; start = 1'b0; found = 1'b0; cand = '0;
    if (m_act) begin
      if (m_phase == (m_ill ? 2 : 3)) begin
        n_ptr = (int'(m_w) + 1 >= int'(NREQ)) ? '0 : m_w + 1'b1;
        n_act = 1'b0;
`ifdef BUS_XFER_B2B_EN
        start = |bus.req;
`endif
      end else begin
        n_phase = m_phase + 1;
      end
    end else begin
      start = |bus.req;
    end
    if (start) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        cand = PW'((int'(n_ptr) + i) % int'(NREQ));
        if (!found && bus.req[cand]) begin
          found = 1'b1;
          n_w   = cand;
        end
      end
      n_s     = SW'(bus.src_sel >> (int'(n_w) * SW));
      n_d     = SW'(bus.dst_sel >> (int'(n_w) * SW));
      n_ill   = (n_s == n_d);
      n_phase = 0;
      n_act   = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= '0; m_w <= '0; m_s <= '0; m_d <= '0;
      m_act <= 1'b0; m_ill <= 1'b0; m_phase <= 0;
    end else begin
      m_ptr <= n_ptr; m_w <= n_w; m_s <= n_s; m_d <= n_d;
      m_act <= n_act; m_ill <= n_ill; m_phase <= n_phase;
    end
  end

  logic [NREQ-1:0]  e_gnt, e_done;
  logic             e_err, e_busy;
  logic [NREGS-1:0] e_cs, e_oe, e_we;
  always @* begin
    e_gnt = '0; e_done = '0; e_err = 1'b0; e_busy = m_act;
    e_cs = '0; e_oe = '0; e_we = '0;
    if (m_act) begin
      if (m_phase == 0) e_gnt[m_w] = 1'b1;
      if (m_phase == (m_ill ? 1 : 2)) begin
        e_done[m_w] = 1'b1;
        e_err       = m_ill;
      end
      if (!m_ill && (m_phase == 1 || m_phase == 2)) begin
        e_cs[m_s] = 1'b1;
        e_oe[m_s] = 1'b1;
      end
      if (!m_ill && m_phase == 2) begin
        e_cs[m_d] = 1'b1;
        e_we[m_d] = 1'b1;
      end
    end
  end

  logic [17:0] obs, expv;
  logic [14:0] obs3;
  assign obs  = {bus.gnt, bus.done, bus.err, bus.busy, bus.CS, bus.OE, bus.WE};
  assign expv = {e_gnt, e_done, e_err, e_busy, e_cs, e_oe, e_we};
  assign obs3 = {bus3.gnt, bus3.done, bus3.err, bus3.busy, bus3.CS, bus3.OE, bus3.WE};

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;  bus.src_sel = '0;  bus.dst_sel = '0;
    bus3.req = '0; bus3.src_sel = '0; bus3.dst_sel = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 18'h0) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", obs, 18'h0);
    end
    n_cmp++;
    if (obs3 !== 15'h0) begin
      n_fail++; $display("FAIL reset_state3 got=%h want=%h", obs3, 15'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 18'h0) begin
      n_fail++; $display("FAIL idle_after_reset got=%h want=%h", obs, 18'h0);
    end
  endtask

  // Single move 0->2; req drops and selects change right after the grant.
  task automatic test_single_move();
    logic [17:0] tab [5];
    tab[0] = {2'b01, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tab[1] = {2'b00, 2'b00, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000};
    tab[2] = {2'b00, 2'b01, 1'b0, 1'b1, 4'b0101, 4'b0001, 4'b0100};
    tab[3] = {2'b00, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tab[4] = 18'h0;
    bus.src_sel = {2'd0, 2'd0};
    bus.dst_sel = {2'd0, 2'd2};
    bus.req     = 2'b01;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== tab[c]) begin
        n_fail++; $display("FAIL single_move cyc=%0d got=%h want=%h", c + 1, obs, tab[c]);
      end
      if (c == 0) begin
        bus.req     = 2'b00;
        bus.src_sel = {2'd0, 2'd3};
        bus.dst_sel = {2'd0, 2'd1};
      end
    end
    n_cmp++;
    if (rf[2] !== 8'hBF) begin
      n_fail++; $display("FAIL single_move_data got=%h want=%h", rf[2], 8'hBF);
    end
  endtask

  // Reset lands while requester 1 is in its write cycle.
  task automatic test_reset_mid_move();
    bus.src_sel = {2'd1, 2'd0};
    bus.dst_sel = {2'd3, 2'd0};
    bus.req     = 2'b10;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.done !== 2'b10 || bus.WE !== 4'b1000) begin
      n_fail++; $display("FAIL mid_move_write got done=%b WE=%b want done=10 WE=1000", bus.done, bus.WE);
    end
    bus.req = 2'b00;
    rst_n   = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 18'h0) begin
      n_fail++; $display("FAIL mid_move_reset got=%h want=%h", obs, 18'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (rf[3] !== 8'h33) begin
      n_fail++; $display("FAIL mid_move_no_write got=%h want=%h", rf[3], 8'h33);
    end
  endtask

  task automatic test_contention();
    int order [4];
    int ng;
    ng = 0;
    bus.src_sel = {2'd2, 2'd0};
    bus.dst_sel = {2'd3, 2'd1};
    bus.req     = 2'b11;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL contention cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      n_cmp++;
      if ($countones(bus.OE) > 1 || bus.gnt === 2'b11) begin
        n_fail++; $display("FAIL contention_excl cyc=%0d OE=%b gnt=%b", cyc, bus.OE, bus.gnt);
      end
      if (bus.gnt != 2'b00) begin
        order[ng] = int'(bus.gnt[1]);
        ng++;
        if (ng == 4) bus.req = 2'b00;
      end
    end
    n_cmp++;
    if (ng != 4) begin
      n_fail++; $display("FAIL contention_grants got=%0d want=4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (order[i] != i % 2) begin
          n_fail++; $display("FAIL contention_order idx=%0d got=%0d want=%0d", i, order[i], i % 2);
        end
      end
    end
    for (int k = 0; k < 10 && bus.busy; k++) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dcyc [3];
    int nd;
    nd = 0;
    bus.src_sel = {2'd2, 2'd0};
    bus.dst_sel = {2'd3, 2'd1};
    bus.req     = 2'b11;
    for (int cyc = 0; cyc < 40 && nd < 3; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      if (bus.done != 2'b00) begin
        dcyc[nd] = cyc;
        nd++;
        if (nd == 3) bus.req = 2'b00;
      end
    end
    n_cmp++;
    if (nd != 3) begin
      n_fail++; $display("FAIL b2b_dones got=%0d want=3", nd);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (dcyc[i] - dcyc[i-1] != MOVE_GAP) begin
          n_fail++; $display("FAIL b2b_gap idx=%0d got=%0d want=%0d", i, dcyc[i] - dcyc[i-1], MOVE_GAP);
        end
      end
    end
    for (int k = 0; k < 10 && bus.busy; k++) @(negedge clk);
  endtask

  // src==dst on the 4-register bus and dst beyond the last register on the 3-register bus.
  task automatic test_illegal();
    logic [17:0] tab  [4];
    logic [14:0] tab3 [4];
    tab[0]  = {2'b01, 2'b00, 1'b0, 1'b1, 12'h000};
    tab[1]  = {2'b00, 2'b01, 1'b1, 1'b1, 12'h000};
    tab[2]  = {2'b00, 2'b00, 1'b0, 1'b1, 12'h000};
    tab[3]  = 18'h0;
    tab3[0] = {2'b01, 2'b00, 1'b0, 1'b1, 9'h000};
    tab3[1] = {2'b00, 2'b01, 1'b1, 1'b1, 9'h000};
    tab3[2] = {2'b00, 2'b00, 1'b0, 1'b1, 9'h000};
    tab3[3] = 15'h0;
    bus.src_sel  = {2'd0, 2'd1};
    bus.dst_sel  = {2'd0, 2'd1};
    bus.req      = 2'b01;
    bus3.src_sel = {2'd0, 2'd0};
    bus3.dst_sel = {2'd0, 2'd3};
    bus3.req     = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== tab[c]) begin
        n_fail++; $display("FAIL illegal_same cyc=%0d got=%h want=%h", c + 1, obs, tab[c]);
      end
      n_cmp++;
      if (obs3 !== tab3[c]) begin
        n_fail++; $display("FAIL illegal_range cyc=%0d got=%h want=%h", c + 1, obs3, tab3[c]);
      end
      if (c == 0) begin
        bus.req  = 2'b00;
        bus3.req = 2'b00;
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0]    inflight;
    logic [NREQ*SW-1:0] s_tmp, d_tmp;
    logic [SW-1:0]      s, d;
    inflight = '0;
    bus.req  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      n_cmp++;
      if ($countones(bus.OE) > 1 || (bus.OE & ~bus.CS) != '0 ||
          (bus.WE & ~bus.CS) != '0 || (bus.WE & bus.OE) != '0) begin
        n_fail++; $display("FAIL random_inv cyc=%0d CS=%b OE=%b WE=%b", cyc, bus.CS, bus.OE, bus.WE);
      end
      s_tmp = bus.src_sel;
      d_tmp = bus.dst_sel;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.done[i]) begin
          bus.req[i]  = 1'b0;
          inflight[i] = 1'b0;
        end else if (bus.gnt[i]) begin
          inflight[i] = 1'b1;
          if ($urandom_range(1, 0) == 1) bus.req[i] = 1'b0;
          s_tmp[i*SW +: SW] = SW'($urandom_range(3, 0));
          d_tmp[i*SW +: SW] = SW'($urandom_range(3, 0));
        end else if (!bus.req[i] && !inflight[i] && $urandom_range(2, 0) == 0) begin
          s = SW'($urandom_range(3, 0));
          d = ($urandom_range(3, 0) == 0) ? s : SW'($urandom_range(3, 0));
          s_tmp[i*SW +: SW] = s;
          d_tmp[i*SW +: SW] = d;
          bus.req[i] = 1'b1;
        end
      end
      bus.src_sel = s_tmp;
      bus.dst_sel = d_tmp;
    end
    bus.req = '0;
    for (int k = 0; k < 12 && bus.busy; k++) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL random_drain got busy=%b want 0", bus.busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_move();
    test_reset_mid_move();
    test_contention();
    test_back_to_back();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
